easyaxi_rd_mst: RTL

// AXI read master, directly upstream of the EasyAXI read slave: drives its AR channel, consumes its R channel.
// - Accepts read commands from a local command port and assigns a rotating ARID.
// - Registers each command onto AR.
// - Tracks up to OST_DEPTH outstanding bursts; R beats pass through to a local data port.
// - Checks every beat against the expected ID/length; protocol violations set a sticky error.

---
 rtl/easyaxi_rd_mst.sv | 134 +++++++++++++
 1 files changed

// File: rtl/easyaxi_rd_mst.sv
// easyaxi_rd_mst: AXI read master issuing AR bursts and checking in-order R responses
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module easyaxi_rd_mst #(
  parameter int OST_DEPTH = 16,
  parameter int MAX_LEN   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [`AXI_ADDR_W-1:0]     cmd_addr,
  input  logic [`AXI_LEN_W-1:0]      cmd_len,
  input  logic [`AXI_SIZE_W-1:0]     cmd_size,
  input  logic [`AXI_BURST_W-1:0]    cmd_burst,
  output logic                       axi_mst_arvalid,
  output logic [`AXI_ID_W-1:0]       axi_mst_arid,
  output logic [`AXI_ADDR_W-1:0]     axi_mst_araddr,
  output logic [`AXI_LEN_W-1:0]      axi_mst_arlen,
  output logic [`AXI_SIZE_W-1:0]     axi_mst_arsize,
  output logic [`AXI_BURST_W-1:0]    axi_mst_arburst,
  input  logic                       axi_mst_arready,
  input  logic                       axi_mst_rvalid,
  input  logic [`AXI_ID_W-1:0]       axi_mst_rid,
  input  logic [`AXI_DATA_W-1:0]     axi_mst_rdata,
  input  logic [`AXI_RESP_W-1:0]     axi_mst_rresp,
  input  logic                       axi_mst_rlast,
  output logic                       axi_mst_rready,
  output logic                       dat_valid,
  input  logic                       dat_ready,
  output logic [`AXI_ID_W-1:0]       dat_id,
  output logic [`AXI_DATA_W-1:0]     dat_data,
  output logic [`AXI_RESP_W-1:0]     dat_resp,
  output logic                       dat_last,
  output logic [$clog2(OST_DEPTH):0] ost_cnt,
  output logic                       prot_err
);
  localparam int PW = $clog2(OST_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = `AXI_ID_W;
  localparam int LW = `AXI_LEN_W;
  localparam int AW = `AXI_ADDR_W;
  localparam int SW = `AXI_SIZE_W;
  localparam int BW = `AXI_BURST_W;
  localparam int PLW = IW + AW + LW + SW + BW;
  logic           arvalid_q, arvalid_d;
  logic [PLW-1:0] ar_q, ar_d;
  logic [IW-1:0]  id_q, id_d;
  logic [CW-1:0]  ost_q, ost_d;
  logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]  beat_q, beat_d;
  logic           prot_err_q, prot_err_d;
  logic [IW+LW-1:0] mem_q [OST_DEPTH];
  logic accept, ar_hs, r_hs, empty, at_end, pop, bad;
  logic [IW-1:0] head_id;
  logic [LW-1:0] head_len;
  assign {axi_mst_arid, axi_mst_araddr, axi_mst_arlen, axi_mst_arsize, axi_mst_arburst} = ar_q;
  assign axi_mst_arvalid = arvalid_q;
  assign axi_mst_rready = dat_ready;
  assign dat_valid = axi_mst_rvalid;
  assign dat_id = axi_mst_rid;
  assign dat_data = axi_mst_rdata;
  assign dat_resp = axi_mst_rresp;
  assign dat_last = axi_mst_rlast;
  assign ost_cnt = ost_q;
  assign prot_err = prot_err_q;
  // Handshakes, head-of-FIFO decode and beat checks; the FIFO occupancy equals ost_cnt
  always_comb begin
    cmd_ready = enable & (~arvalid_q | axi_mst_arready) & (ost_q < CW'(OST_DEPTH)) & (cmd_len < LW'(MAX_LEN));
    accept = cmd_valid & cmd_ready;
    ar_hs = arvalid_q & axi_mst_arready;
    r_hs = axi_mst_rvalid & dat_ready;
    empty = ost_q == '0;
    {head_id, head_len} = mem_q[rd_q];
    at_end = beat_q == head_len;
    pop = r_hs & ~empty & (axi_mst_rlast | at_end);
    bad = r_hs & (empty | (axi_mst_rid != head_id) | (axi_mst_rlast != at_end));
    arvalid_d = accept | (arvalid_q & ~ar_hs);
    ar_d = accept ? {id_q, cmd_addr, cmd_len, cmd_size, cmd_burst} : ar_q;
    id_d = id_q + IW'(accept);
    ost_d = ost_q + CW'(accept) - CW'(pop);
    wr_d = wr_q + PW'(accept);
    rd_d = rd_q + PW'(pop);
    beat_d = r_hs ? ((axi_mst_rlast | pop) ? '0 : beat_q + 1'b1) : beat_q;
    prot_err_d = prot_err_q | bad;
  end
  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      arvalid_q <= 1'b0;
      ar_q <= '0;
      id_q <= '0;
      ost_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      beat_q <= '0;
      prot_err_q <= 1'b0;
    end else begin
      arvalid_q <= arvalid_d;
      ar_q <= ar_d;
      id_q <= id_d;
      ost_q <= ost_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      beat_q <= beat_d;
      prot_err_q <= prot_err_d;
    end
  end
  // Expected-burst storage: {id, len} written at command accept
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_q] <= {id_q, cmd_len};
  end
endmodule
